stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
// PURPOSE
//  Parametrised N-input, WIDTH-bit multiplexer with valid/ready handshake per input and one
//  registered output stage. Successor to the plain combinational 4-to-1 select mux.
//  Arbitrates pipeline sources (PC-next candidates, writeback/forwarding producers) in either
//  externally-selected or round-robin mode, and supports stall (out_ready low) and flush.
// PARAMETERS
//  WIDTH   32             data width of each input and of the output
//  N       4              number of input channels (>=2)
//  SEL_W   $clog2(N)      width of sel and out_src (derived; do not override)
//  MODE    MUX_MODE_SEL   MUX_MODE_SEL = channel chosen by sel; MUX_MODE_RR = round-robin over in_valid
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous reset, active-high
//  flush      in   1          synchronous flush: drop the held output word
//  in_data    in   N x WIDTH  per-channel data (unpacked array [N])
//  in_valid   in   N          per-channel valid
//  in_ready   out  N          per-channel ready; at most one bit high per cycle
//  sel        in   SEL_W      channel select (MUX_MODE_SEL only; ignored in RR)
//  out_data   out  WIDTH      registered output data
//  out_valid  out  1          output register holds a word
//  out_ready  in   1          downstream accepts out_data this cycle
//  out_src    out  SEL_W      index of the channel that supplied out_data
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1 (channel 0 has first priority).
//  - space = !out_valid || out_ready. Output stage is a single pipeline register; latency 1 cycle
//    from input transfer to out_valid; full throughput (1 word/cycle) when out_ready held high.
//  - Input transfer on channel i when in_valid[i] && in_ready[i]; at most one per cycle.
//  - SEL mode: grant = sel. in_ready[i] = (i==sel) && space && !flush, independent of in_valid.
//    sel >= N: no grant, all in_ready=0, no transfer.
//  - RR mode: grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... wrapping mod N.
//    in_ready[i] = grant[i] && space && !flush. rr_ptr <= granted index only on a transfer;
//    no valid inputs or no space: rr_ptr unchanged.
//  - Transfer: out_data <= in_data[g], out_src <= g, out_valid <= 1.
//  - No transfer and out_ready && out_valid: out_valid <= 0; out_data/out_src hold last value.
//  - Stall (out_valid && !out_ready): out_data/out_src/out_valid stable; all in_ready=0.
//  - flush=1: out_valid <= 0 next cycle, no input accepted this cycle (flush beats transfer),
//    rr_ptr unchanged, out_data/out_src hold.
//  - Reset mid-operation: immediate clear per reset values; a word being held is dropped.
//  - in_ready must not depend on out_valid's next state; only current registers, sel, in_valid, flush, out_ready.
// STRUCTURE
//  - Package mips_mux_pkg: typedef enum logic {MUX_MODE_SEL, MUX_MODE_RR} mux_mode_e; function
//    clog2 helper if tool lacks $clog2 in params.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr, outputs one-hot gnt[N], gnt_idx, any_gnt.
//    Instantiated only in MUX_MODE_RR (generate); SEL mode decodes sel directly.
//  - Top: grant selection, in_ready decode, output register, rr_ptr register.
// TESTING
//  1 SEL, N=4: sel=2, in_valid=4'b1111, in_data={D,C,B,A}, out_ready=1 -> next cycle out_data=C, out_src=2, in_ready=4'b0100.
//  2 SEL: sel=3 on cycle k, sel=0 on k+1 (valids high, out_ready=1) -> out_data D then A on consecutive cycles, out_valid continuous.
//  3 RR: all four valid for 8 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0,1,2,3; in_valid=4'b1010 -> 1,3,1,3.
//  4 Stall: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_src stable, in_ready=0, rr_ptr unchanged; release -> next grant resumes.
//  5 Flush with in_valid[1]=1 and space: flush=1 -> no in_ready, out_valid=0 next cycle, word on ch1 accepted next cycle.
//  6 Async reset asserted between clock edges while out_valid=1 -> out_valid=0, out_data=0 immediately; after release RR grants ch0 first.

Source files
------------

// File: rtl/stream_mux_n_pkg.sv
// Shared types and helpers for the N-input stream multiplexer.
package mips_mux_pkg;

  // Grant policy: external select or round-robin over the valid inputs.
  typedef enum logic {
    MUX_MODE_SEL = 1'b0,
    MUX_MODE_RR  = 1'b1
  } mux_mode_e;

  // Ceiling log2 for parameter derivation; never returns less than 1 so a
  // two-channel mux still gets a one-bit select.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between the channel producers, the mux and the consumer.
// Handshake rule for every channel and for the output: a word moves on a
// rising clock edge exactly when its valid and its ready are both high;
// valid never waits on ready, and ready is allowed to depend on valid.
interface stream_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic             flush;
  logic [WIDTH-1:0] in_data [N];
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_src;
  logic [SEL_W-1:0] dbg_rr_ptr;

  // Producer/consumer side of the mux.
  modport master (
    output flush, in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src, dbg_rr_ptr
  );

  // The mux itself.
  modport slave (
    input  flush, in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src, dbg_rr_ptr
  );
endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter
  import mips_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_any_gnt
);

  logic [SEL_W-1:0] w_c;

  // Walk ptr+1 .. ptr+N and keep the first requester found.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any_gnt = 1'b0;
    w_c       = '0;
    for (int k = 1; k <= N; k++) begin
      w_c = SEL_W'((int'(i_ptr) + k) % N);
      if (!o_any_gnt && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_gnt_idx  = w_c;
        o_any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-input stream mux with one registered output stage, select or
// round-robin grant, stall via out_ready and a synchronous flush.
module stream_mux_n
  import mips_mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter int        SEL_W = clog2(N),
  parameter mux_mode_e MODE  = MUX_MODE_SEL
) (
  input logic          clk,
  input logic          rst,
  stream_mux_n_if.slave bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_space;
  logic             w_any_gnt;
  logic             w_xfer;
  logic [N-1:0]     w_gnt;
  logic [N-1:0]     w_in_ready;
  logic [SEL_W-1:0] w_gnt_idx;

  // The register can take a word if it is empty or being drained now.
  assign w_space = !r_out_valid || bus.out_ready;

  if (MODE == MUX_MODE_RR) begin : g_rr
    rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
    ) u_arb (
      .i_req     (bus.in_valid),
      .i_ptr     (r_rr_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any_gnt (w_any_gnt)
    );
  end else begin : g_sel
    // Decode sel regardless of in_valid; an out-of-range sel grants nobody.
    always_comb begin
      w_gnt = '0;
      for (int i = 0; i < N; i++) begin
        w_gnt[i] = (int'(bus.sel) == i);
      end
    end
    assign w_gnt_idx = bus.sel;
    assign w_any_gnt = |w_gnt;
  end

  // Ready uses only current state and inputs, never the next out_valid.
  assign w_in_ready = (w_space && !bus.flush && w_any_gnt) ? w_gnt : '0;
  assign w_xfer     = |(w_in_ready & bus.in_valid);

  assign bus.in_ready   = w_in_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_src    = r_out_src;
  assign bus.dbg_rr_ptr = r_rr_ptr;

  // Output pipeline register: flush drops the word, transfer loads, drain clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[w_gnt_idx];
      r_out_src   <= w_gnt_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer remembers the last channel that actually moved data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= SEL_W'(N - 1);
    end else if (MODE == MUX_MODE_RR && w_xfer) begin
      r_rr_ptr <= w_gnt_idx;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one SEL-mode and one RR-mode instance, each checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_stream_mux_n;
  import mips_mux_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables (index 0 = SEL dut, 1 = RR dut) ----
  logic [W-1:0] t_data [2][N];
  logic [N-1:0] t_valid [2];
  logic         t_out_ready [2];
  logic         t_flush [2];
  logic [1:0]   t_sel;

  stream_mux_n_if #(.WIDTH(W), .N(N), .SEL_W(2)) if_sel ();
  stream_mux_n_if #(.WIDTH(W), .N(N), .SEL_W(2)) if_rr ();

  stream_mux_n #(.WIDTH(W), .N(N), .SEL_W(2), .MODE(MUX_MODE_SEL)) u_sel (
    .clk (clk), .rst (rst), .bus (if_sel)
  );
  stream_mux_n #(.WIDTH(W), .N(N), .SEL_W(2), .MODE(MUX_MODE_RR)) u_rr (
    .clk (clk), .rst (rst), .bus (if_rr)
  );

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign if_sel.in_data[i] = t_data[0][i];
    assign if_rr.in_data[i]  = t_data[1][i];
  end
  assign if_sel.in_valid  = t_valid[0];
  assign if_rr.in_valid   = t_valid[1];
  assign if_sel.out_ready = t_out_ready[0];
  assign if_rr.out_ready  = t_out_ready[1];
  assign if_sel.flush     = t_flush[0];
  assign if_rr.flush      = t_flush[1];
  assign if_sel.sel       = t_sel;
  assign if_rr.sel        = t_sel;

  logic         o_valid [2];
  logic [W-1:0] o_data [2];
  logic [1:0]   o_src [2];
  logic [N-1:0] o_ready [2];
  assign o_valid[0] = if_sel.out_valid;
  assign o_valid[1] = if_rr.out_valid;
  assign o_data[0]  = if_sel.out_data;
  assign o_data[1]  = if_rr.out_data;
  assign o_src[0]   = if_sel.out_src;
  assign o_src[1]   = if_rr.out_src;
  assign o_ready[0] = if_sel.in_ready;
  assign o_ready[1] = if_rr.in_ready;

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds {src,data} of the word sitting in the output stage.
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [33:0] m_hold [2];   // last word ever loaded (out_data holds it)
  int          m_ptr;        // round-robin: last channel served

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int d, input logic [33:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_hold[0] = '0;
    m_hold[1] = '0;
    m_ptr     = N - 1;
  endtask

  // Channel that would be granted this cycle, or -1.
  function automatic int grant(input int d);
    int c;
    if (d == 0) return int'(t_sel);
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (t_valid[1][c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int d);
    int   g;
    logic space;
    g     = grant(d);
    space = (q_size(d) == 0) || t_out_ready[d];
    if (g >= 0 && space && !t_flush[d]) return N'(1 << g);
    return '0;
  endfunction

  task automatic check_all();
    logic [33:0] h;
    for (int d = 0; d < 2; d++) begin
      h = m_hold[d];
      chk($sformatf("d%0d out_valid", d), 64'(o_valid[d]), 64'(q_size(d) != 0));
      chk($sformatf("d%0d out_data", d), 64'(o_data[d]), 64'(h[31:0]));
      chk($sformatf("d%0d out_src", d), 64'(o_src[d]), 64'(h[33:32]));
      chk($sformatf("d%0d in_ready", d), 64'(o_ready[d]), 64'(exp_ready(d)));
    end
    chk("rr_ptr", 64'(if_rr.dbg_rr_ptr), 64'(m_ptr[1:0]));
  endtask

  // One clock: check at negedge, predict, take the edge, commit model.
  task automatic step();
    logic        pop [2];
    logic        push [2];
    logic [33:0] ent [2];
    int          g;
    int          nptr;
    @(negedge clk);
    check_all();
    nptr = m_ptr;
    for (int d = 0; d < 2; d++) begin
      g       = grant(d);
      pop[d]  = (q_size(d) != 0) && (t_flush[d] || t_out_ready[d]);
      push[d] = (exp_ready(d) & t_valid[d]) != '0;
      ent[d]  = '0;
      if (push[d]) begin
        ent[d] = {g[1:0], t_data[d][g[1:0]]};
        if (d == 1) nptr = g;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pop[d]) q_pop(d);
      if (push[d]) begin
        q_push(d, ent[d]);
        m_hold[d] = ent[d];
      end
    end
    m_ptr = nptr;
  endtask

  task automatic rand_data(input int d);
    for (int i = 0; i < N; i++) t_data[d][i] = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] w_c;
    logic [W-1:0] w_d;
    logic [W-1:0] w_a;
    logic [1:0]   w_src;

    rst = 1'b1;
    t_sel = 2'd0;
    for (int d = 0; d < 2; d++) begin
      t_valid[d] = '0; t_out_ready[d] = 1'b0; t_flush[d] = 1'b0;
      for (int i = 0; i < N; i++) t_data[d][i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // SEL: sel=2 picks C; then sel 3, sel 0 back to back.
    rand_data(0);
    w_a = t_data[0][0]; w_c = t_data[0][2]; w_d = t_data[0][3];
    t_valid[0] = 4'b1111; t_out_ready[0] = 1'b1; t_sel = 2'd2;
    #1 chk("sel2 in_ready", 64'(o_ready[0]), 64'(4'b0100));
    step();
    chk("sel2 out_data", 64'(o_data[0]), 64'(w_c));
    chk("sel2 out_src", 64'(o_src[0]), 64'd2);
    t_sel = 2'd3;
    step();
    chk("sel3 out_data", 64'(o_data[0]), 64'(w_d));
    t_sel = 2'd0;
    step();
    chk("sel0 out_data", 64'(o_data[0]), 64'(w_a));
    chk("sel0 out_valid", 64'(o_valid[0]), 64'd1);

    // RR: all valid -> 0,1,2,3,0,1,2,3.
    rand_data(1);
    t_valid[1] = 4'b1111; t_out_ready[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr all src%0d", i), 64'(o_src[1]), 64'(i % 4));
    end
    t_valid[1] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr 1010 src%0d", i), 64'(o_src[1]), 64'((i % 2) ? 3 : 1));
    end

    // Stall: output held, nothing accepted, pointer frozen.
    t_out_ready[1] = 1'b0;
    w_d = o_data[1];
    w_src = o_src[1];
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall data", 64'(o_data[1]), 64'(w_d));
      chk("stall src", 64'(o_src[1]), 64'(w_src));
      chk("stall ready", 64'(o_ready[1]), 64'd0);
      chk("stall ptr", 64'(if_rr.dbg_rr_ptr), 64'd3);
    end
    t_out_ready[1] = 1'b1;
    step();
    chk("stall release src", 64'(o_src[1]), 64'd1);

    // Flush with ch1 waiting.
    t_valid[1] = 4'b0010; t_flush[1] = 1'b1;
    #1 chk("flush in_ready", 64'(o_ready[1]), 64'd0);
    step();
    chk("flush out_valid", 64'(o_valid[1]), 64'd0);
    t_flush[1] = 1'b0;
    step();
    chk("post flush valid", 64'(o_valid[1]), 64'd1);
    chk("post flush src", 64'(o_src[1]), 64'd1);
    chk("post flush data", 64'(o_data[1]), 64'(t_data[1][1]));

    // Async reset between edges while holding a word.
    t_valid[1] = 4'b1111;
    step();
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", 64'(o_valid[1]), 64'd0);
    chk("async rst data", 64'(o_data[1]), 64'd0);
    chk("async rst sel valid", 64'(o_valid[0]), 64'd0);
    model_reset();
    rst = 1'b0;
    step();
    chk("rst first grant", 64'(o_src[1]), 64'd0);

    // Random traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        rand_data(d);
        t_valid[d]     = N'($urandom_range(0, 15));
        t_out_ready[d] = ($urandom_range(0, 3) != 0);
        t_flush[d]     = ($urandom_range(0, 9) == 0);
      end
      t_sel = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
